// File: rtl/csr_pkg.sv
// csr_pkg: state encoding, load-target codes and sizing helper shared by the CSR SpMV engine.
package csr_pkg;
  typedef enum logic [2:0] {IDLE, PTR0, PTR1, MAC, EMIT, FIN} state_e;
  localparam logic [1:0] SEL_VAL = 2'd0;
  localparam logic [1:0] SEL_COL = 2'd1;
  localparam logic [1:0] SEL_PTR = 2'd2;
  localparam logic [1:0] SEL_X   = 2'd3;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/csr_ram.sv
// csr_ram: single-clock simple dual-port memory with one-cycle synchronous read.
module csr_ram #(
  parameter int W = 32,
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/csr_spmv_engine.sv
// csr_spmv_engine: CSR sparse-matrix x dense-vector multiply, one signed dot product per row.
// Row pointers are prefetched one cycle ahead so PTR0/PTR1 each see a fresh row_ptr word.
module csr_spmv_engine
  import csr_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NNZ_DEPTH = 1024,
  parameter int MAX_ROWS = 256,
  parameter int ACC_W = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                in_sel,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      start,
  input  logic [clog2(MAX_ROWS):0]  num_rows,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [clog2(MAX_ROWS)-1:0] out_row,
  output logic [ACC_W-1:0]          out_data,
  output logic                      out_zero,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);
  localparam int RW = clog2(MAX_ROWS) + 1;
  localparam int KW = clog2(NNZ_DEPTH);
  localparam int XW = clog2(MAX_ROWS);
  state_e state_q;
  logic [RW-1:0] r_q, rows_q;
  logic [DATA_W-1:0] k_q, end_q, val_q;
  logic [31:0] cnt_q [4];
  logic [ACC_W-1:0] acc_q;
  logic s1_q, s2_q, oob_q, zero_q, err_q;
  logic [DATA_W-1:0] val_rd, col_rd, ptr_rd, x_rd;
  logic [31:0] cap;
  logic wr, full, issue, oob;
  logic [3:0] we;
  logic signed [ACC_W-1:0] prod;
  assign wr = in_valid && state_q == IDLE;
  assign cap = in_sel == SEL_X ? 32'(MAX_ROWS) : in_sel == SEL_PTR ? 32'(MAX_ROWS + 1) : 32'(NNZ_DEPTH);
  assign full = cnt_q[in_sel] >= cap;
  assign we = wr && !full ? 4'b0001 << in_sel : 4'b0000;
  assign issue = state_q == MAC && k_q < end_q;
  assign oob = col_rd >= DATA_W'(MAX_ROWS);
  assign prod = ACC_W'($signed(val_q)) * ACC_W'($signed(x_rd));
  csr_ram #(.W(DATA_W), .DEPTH(NNZ_DEPTH), .AW(KW)) u_val (
    .clk(clk), .we(we[SEL_VAL]), .waddr(KW'(cnt_q[SEL_VAL])), .wdata(in_data),
    .raddr(KW'(k_q)), .rdata(val_rd));
  csr_ram #(.W(DATA_W), .DEPTH(NNZ_DEPTH), .AW(KW)) u_col (
    .clk(clk), .we(we[SEL_COL]), .waddr(KW'(cnt_q[SEL_COL])), .wdata(in_data),
    .raddr(KW'(k_q)), .rdata(col_rd));
  csr_ram #(.W(DATA_W), .DEPTH(MAX_ROWS + 1), .AW(RW)) u_ptr (
    .clk(clk), .we(we[SEL_PTR]), .waddr(RW'(cnt_q[SEL_PTR])), .wdata(in_data),
    .raddr(state_q == IDLE ? '0 : r_q + RW'(1)), .rdata(ptr_rd));
  csr_ram #(.W(DATA_W), .DEPTH(MAX_ROWS), .AW(XW)) u_x (
    .clk(clk), .we(we[SEL_X]), .waddr(XW'(cnt_q[SEL_X])), .wdata(in_data),
    .raddr(XW'(col_rd)), .rdata(x_rd));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      r_q <= '0;
      rows_q <= '0;
      k_q <= '0;
      end_q <= '0;
      val_q <= '0;
      cnt_q <= '{default: '0};
      acc_q <= '0;
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      oob_q <= 1'b0;
      zero_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      s1_q <= issue;
      s2_q <= s1_q;
      val_q <= val_rd;
      oob_q <= oob;
      if (s2_q) acc_q <= acc_q + (oob_q ? '0 : prod);
      if ((s1_q && oob) || (wr && full)) err_q <= 1'b1;
      if (wr && !full) cnt_q[in_sel] <= cnt_q[in_sel] + 1;
      case (state_q)
        IDLE: if (start) begin
          cnt_q <= '{default: '0};
          r_q <= '0;
          rows_q <= num_rows;
          state_q <= num_rows == '0 ? FIN : PTR0;
        end
        PTR0: begin
          acc_q <= '0;
          k_q <= ptr_rd;
          state_q <= PTR1;
        end
        PTR1: begin
          end_q <= ptr_rd;
          zero_q <= ptr_rd == k_q;
          state_q <= ptr_rd == k_q ? EMIT : MAC;
        end
        MAC: begin
          if (issue) k_q <= k_q + 1'b1;
          if (!issue && !s1_q) state_q <= EMIT;
        end
        EMIT: if (out_ready) begin
          r_q <= r_q + 1'b1;
          state_q <= r_q + 1'b1 == rows_q ? FIN : PTR0;
        end
        FIN: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign in_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign out_valid = state_q == EMIT;
  assign done = state_q == FIN;
  assign out_row = r_q[RW-2:0];
  assign out_data = acc_q;
  assign out_zero = zero_q;
  assign err = err_q;
endmodule
